openram_scan_driver: RTL and testbench

OPENRAM_SCAN_DRIVER -- requirements
Module: openram_scan_driver

---
 rtl/openram_scan_pkg.sv | 49 ++++
 rtl/openram_scan_driver.sv | 132 +++++++++++++
 tb/tb_openram_scan_driver.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/openram_scan_pkg.sv
// Shared parameters, instruction-register field map and FSM encoding for the
// OpenRAM testchip scan driver.
package openram_scan_pkg;

  localparam int unsigned SCAN_LEN   = 112;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WAIT_CYC   = 2;

  // Instruction register field map (bit offsets into the SCAN_LEN image)
  localparam int unsigned CS_MSB     = 111;
  localparam int unsigned CS_LSB     = 108;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned WMASK_W    = 4;
  localparam int unsigned ADDR0_LSB  = 92;
  localparam int unsigned DOUT0_LSB  = 60;
  localparam int unsigned CSB0_BIT   = 59;
  localparam int unsigned WEB0_BIT   = 58;
  localparam int unsigned WMASK0_LSB = 54;
  localparam int unsigned ADDR1_LSB  = 38;
  localparam int unsigned DOUT1_LSB  = 6;
  localparam int unsigned CSB1_BIT   = 5;
  localparam int unsigned WEB1_BIT   = 4;
  localparam int unsigned WMASK1_LSB = 0;

  // Packed view of the instruction image, MSB first
  typedef struct packed {
    logic [3:0]         cs;
    logic [ADDR_W-1:0]  addr0;
    logic [DATA_W-1:0]  din0;
    logic               csb0;
    logic               web0;
    logic [WMASK_W-1:0] wmask0;
    logic [ADDR_W-1:0]  addr1;
    logic [DATA_W-1:0]  din1;
    logic               csb1;
    logic               web1;
    logic [WMASK_W-1:0] wmask1;
  } scan_word_t;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    WAIT,
    LOAD,
    SHIFT_OUT,
    DONE
  } scan_state_e;

endpackage

// File: rtl/openram_scan_driver.sv
// Drives the OpenRAM testchip scan interface: MSB-first instruction scan-in,
// SRAM capture and LSB-first serial readback of both data ports.
module openram_scan_driver
  import openram_scan_pkg::*;
#(
  parameter int unsigned SCAN_LEN = openram_scan_pkg::SCAN_LEN,
  parameter int unsigned DATA_W   = openram_scan_pkg::DATA_W,
  parameter int unsigned WAIT_CYC = openram_scan_pkg::WAIT_CYC
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [SCAN_LEN-1:0] cmd_word,
  input  logic                cmd_read,
  output logic                gpio_bit,
  output logic                gpio_in_scan,
  output logic                gpio_sram_load,
  output logic                gpio_out_scan,
  output logic                in_select,
  input  logic                gpio_data0,
  input  logic                gpio_data1,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data0,
  output logic [DATA_W-1:0]   rsp_data1,
  output logic                busy
);

  localparam int unsigned CNT_W  = $clog2(SCAN_LEN + 1);
  localparam int unsigned IDX_W  = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
  localparam int unsigned DIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  scan_state_e         state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [SCAN_LEN-1:0] word_q, word_nx;
  logic                read_q, read_nx;
  logic [IDX_W-1:0]    bit_idx;
  logic [DIDX_W-1:0]   smp_idx;
  logic                accept;
  logic                gpio_bit_nx, in_scan_nx, sram_load_nx, out_scan_nx;
  logic                rsp_valid_nx, busy_nx, cmd_ready_nx;
  logic [DATA_W-1:0]   data0_nx, data1_nx;

  // State, counter, latched command and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      word_q         <= '0;
      read_q         <= 1'b0;
      gpio_bit       <= 1'b0;
      gpio_in_scan   <= 1'b0;
      gpio_sram_load <= 1'b0;
      gpio_out_scan  <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data0      <= '0;
      rsp_data1      <= '0;
      busy           <= 1'b0;
      cmd_ready      <= 1'b1;
      in_select      <= 1'b1;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      word_q         <= word_nx;
      read_q         <= read_nx;
      gpio_bit       <= gpio_bit_nx;
      gpio_in_scan   <= in_scan_nx;
      gpio_sram_load <= sram_load_nx;
      gpio_out_scan  <= out_scan_nx;
      rsp_valid      <= rsp_valid_nx;
      rsp_data0      <= data0_nx;
      rsp_data1      <= data1_nx;
      busy           <= busy_nx;
      cmd_ready      <= cmd_ready_nx;
      in_select      <= 1'b1;
    end
  end

  // Next state plus the values every output register takes with it
  always_comb begin
    state_nx     = state;
    accept       = 1'b0;
    word_nx      = word_q;
    read_nx      = read_q;
    cnt_nx       = '0;
    data0_nx     = rsp_data0;
    data1_nx     = rsp_data1;
    bit_idx      = '0;
    smp_idx      = DIDX_W'(cnt);
    gpio_bit_nx  = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nx = SHIFT_IN;
          accept   = 1'b1;
        end
      end
      SHIFT_IN:  if (cnt == CNT_W'(SCAN_LEN - 1)) state_nx = WAIT;
      WAIT:      if (cnt == CNT_W'(WAIT_CYC - 1)) state_nx = read_q ? LOAD : DONE;
      LOAD:      state_nx = SHIFT_OUT;
      SHIFT_OUT: if (cnt == CNT_W'(DATA_W - 1)) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase

    if (accept) begin
      word_nx = cmd_word;
      read_nx = cmd_read;
    end

    // Counter restarts on every state entry and is held at zero in IDLE
    if ((state_nx == state) && (state != IDLE)) cnt_nx = cnt + CNT_W'(1);

    // Shift source indexes the latched image; on accept it reads cmd_word directly
    bit_idx = IDX_W'(SCAN_LEN - 1) - IDX_W'(cnt_nx);
    if (state_nx == SHIFT_IN) gpio_bit_nx = word_nx[bit_idx];

    if (state == SHIFT_OUT) begin
      data0_nx[smp_idx] = gpio_data0;
      data1_nx[smp_idx] = gpio_data1;
    end

    in_scan_nx   = (state_nx == SHIFT_IN);
    sram_load_nx = (state_nx == LOAD);
    out_scan_nx  = (state_nx == SHIFT_OUT);
    rsp_valid_nx = (state_nx == DONE);
    busy_nx      = (state_nx != IDLE);
    cmd_ready_nx = (state_nx == IDLE);
  end

endmodule

// File: tb/tb_openram_scan_driver.sv
// Directed bench: openram_scan_driver paired with a behavioural OpenRAM testchip
// (scan register plus a small two-port SRAM) on a shared clock.
module tb_openram_scan_driver;
  import openram_scan_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                cmd_valid, cmd_ready, cmd_read;
  logic [SCAN_LEN-1:0] cmd_word;
  logic                gpio_bit, gpio_in_scan, gpio_sram_load, gpio_out_scan, in_select;
  logic                gpio_data0, gpio_data1;
  logic                rsp_valid, busy;
  logic [DATA_W-1:0]   rsp_data0, rsp_data1;

  always #5 clk = ~clk;

  openram_scan_driver #(
    .SCAN_LEN (SCAN_LEN),
    .DATA_W   (DATA_W),
    .WAIT_CYC (WAIT_CYC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_word       (cmd_word),
    .cmd_read       (cmd_read),
    .gpio_bit       (gpio_bit),
    .gpio_in_scan   (gpio_in_scan),
    .gpio_sram_load (gpio_sram_load),
    .gpio_out_scan  (gpio_out_scan),
    .in_select      (in_select),
    .gpio_data0     (gpio_data0),
    .gpio_data1     (gpio_data1),
    .rsp_valid      (rsp_valid),
    .rsp_data0      (rsp_data0),
    .rsp_data1      (rsp_data1),
    .busy           (busy)
  );

  // ---------------- testchip model ----------------
  logic [SCAN_LEN-1:0] chip_reg;
  logic [DATA_W-1:0]   mem [0:15][0:15];
  logic [DATA_W-1:0]   dout0, dout1;
  logic                op_pending;
  scan_word_t          ins;

  assign ins        = chip_reg;
  assign gpio_data0 = chip_reg[DOUT0_LSB];
  assign gpio_data1 = chip_reg[DOUT1_LSB];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      chip_reg   <= '0;
      dout0      <= '0;
      dout1      <= '0;
      op_pending <= 1'b0;
      mem[0][3]  <= 32'h1234_5678;
      mem[0][7]  <= 32'hCAFE_F00D;
    end else if (gpio_in_scan) begin
      chip_reg   <= {chip_reg[SCAN_LEN-2:0], gpio_bit};
      op_pending <= 1'b1;
    end else if (gpio_sram_load) begin
      chip_reg[DOUT0_LSB +: DATA_W] <= dout0;
      chip_reg[DOUT1_LSB +: DATA_W] <= dout1;
    end else if (gpio_out_scan) begin
      chip_reg <= chip_reg >> 1;
    end else if (op_pending) begin
      op_pending <= 1'b0;
      if (ins.csb0) dout0 <= '0;
      else if (ins.web0) dout0 <= mem[ins.cs][ins.addr0[3:0]];
      else mem[ins.cs][ins.addr0[3:0]] <= ins.din0;
      if (ins.csb1) dout1 <= '0;
      else if (ins.web1) dout1 <= mem[ins.cs][ins.addr1[3:0]];
      else mem[ins.cs][ins.addr1[3:0]] <= ins.din1;
    end
  end

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_miss = 0;
  int viol = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;
  int lat, waitc, n, cyc, acc_base, rsp_base;
  logic [SCAN_LEN-1:0] img;

  typedef struct {
    logic [SCAN_LEN-1:0] word;
    logic                read;
    int                  lat;
    logic [DATA_W-1:0]   d0;
    logic [DATA_W-1:0]   d1;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SCAN_LEN-1:0] mk(
      input logic [3:0] cs, input logic [3:0] a0, input logic [31:0] d0,
      input logic csb0, input logic web0, input logic [3:0] a1,
      input logic [31:0] d1, input logic csb1, input logic web1);
    scan_word_t w;
    w.cs = cs;       w.addr0 = 16'(a0); w.din0 = d0;  w.csb0 = csb0; w.web0 = web0;
    w.wmask0 = 4'hF; w.addr1 = 16'(a1); w.din1 = d1;  w.csb1 = csb1; w.web1 = web1;
    w.wmask1 = 4'hF;
    return w;
  endfunction

  // Issue one command; returns accept wait, accept-to-rsp_valid latency and the
  // testchip register image seen right after scan-in.
  task automatic run_cmd(input logic [SCAN_LEN-1:0] w, input logic rd,
                         output int l, output int wc, output logic [SCAN_LEN-1:0] im);
    @(negedge clk);
    cmd_word  = w;
    cmd_read  = rd;
    cmd_valid = 1'b1;
    wc = 0;
    while (!cmd_ready && wc < 500) begin
      @(negedge clk);
      wc++;
    end
    im = '0;
    @(posedge clk);
    l = 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!rsp_valid && l < 400) begin
      if (l == int'(SCAN_LEN) + 1) im = chip_reg;
      @(posedge clk);
      l++;
      @(negedge clk);
    end
  endtask

  // Per-cycle invariants and event counters, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    #1;
    if (32'(gpio_in_scan) + 32'(gpio_sram_load) + 32'(gpio_out_scan) > 1) viol++;
    if (busy === cmd_ready) viol++;
    if (in_select !== 1'b1) viol++;
    if (!reset && cmd_valid && cmd_ready) acc_cnt++;
    if (rsp_valid) rsp_cnt++;
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_read  = 1'b0;
    cmd_word  = '0;

    vecs[0] = '{mk(4'd2, 4'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1), 1'b0, 115, 32'h0, 32'h0};
    vecs[1] = '{mk(4'd2, 4'd5, 32'h0, 1'b0, 1'b1, 4'd0, 32'h0, 1'b1, 1'b1), 1'b1, 148, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{mk(4'd1, 4'd9, 32'h0BAD_F00D, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1), 1'b0, 115, 32'hDEAD_BEEF, 32'h0};
    vecs[3] = '{mk(4'd0, 4'd7, 32'h0, 1'b0, 1'b1, 4'd3, 32'h0, 1'b0, 1'b1), 1'b1, 148, 32'hCAFE_F00D, 32'h1234_5678};
    vecs[4] = '{mk(4'd1, 4'd9, 32'h0, 1'b0, 1'b1, 4'd0, 32'h0, 1'b1, 1'b1), 1'b1, 148, 32'h0BAD_F00D, 32'h0};
    vecs[5] = '{mk(4'd3, 4'd0, 32'h0, 1'b1, 1'b1, 4'd2, 32'hA5A5_5A5A, 1'b0, 1'b0), 1'b0, 115, 32'h0BAD_F00D, 32'h0};
    vecs[6] = '{mk(4'd3, 4'd0, 32'h0, 1'b1, 1'b1, 4'd2, 32'h0, 1'b0, 1'b1), 1'b1, 148, 32'h0, 32'hA5A5_5A5A};

    repeat (2) @(negedge clk);
    check("reset_outputs", 128'({gpio_bit, gpio_in_scan, gpio_sram_load, gpio_out_scan, rsp_valid, busy}), 128'(0));
    check("reset_rsp_data", 128'({rsp_data0, rsp_data1}), 128'(0));
    check("reset_insel_ready", 128'({in_select, cmd_ready}), 128'(2'b11));
    reset = 1'b0;

    // Table: issued back to back, each accept lands the cycle after the previous DONE
    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].word, vecs[i].read, lat, waitc, img);
      check($sformatf("v%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
      check($sformatf("v%0d_accept_wait", i), 128'(waitc), 128'(0));
      check($sformatf("v%0d_chip_image", i), 128'(img), 128'(vecs[i].word));
      check($sformatf("v%0d_rsp_data0", i), 128'(rsp_data0), 128'(vecs[i].d0));
      check($sformatf("v%0d_rsp_data1", i), 128'(rsp_data1), 128'(vecs[i].d1));
    end

    // Reset pulse in SHIFT_IN cycle 50 of a read
    @(negedge clk);
    cmd_word  = vecs[1].word;
    cmd_read  = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (50) @(negedge clk);
    rsp_base = rsp_cnt;
    check("mid_shift_in_scan", 128'(gpio_in_scan), 128'(1));
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", 128'({gpio_bit, gpio_in_scan, gpio_sram_load, gpio_out_scan, rsp_valid, busy}), 128'(0));
    check("rst_mid_rsp_data", 128'({rsp_data0, rsp_data1}), 128'(0));
    check("rst_mid_insel_ready", 128'({in_select, cmd_ready}), 128'(2'b11));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("rst_no_rsp_valid", 128'(rsp_cnt - rsp_base), 128'(0));
    run_cmd(vecs[1].word, 1'b1, lat, waitc, img);
    check("post_rst_latency", 128'(lat), 128'(148));
    check("post_rst_accept_wait", 128'(waitc), 128'(0));
    check("post_rst_rsp_data0", 128'(rsp_data0), 128'(32'hDEAD_BEEF));
    check("post_rst_rsp_data1", 128'(rsp_data1), 128'(0));

    // cmd_valid held high across three writes: one accept per IDLE visit
    acc_base = acc_cnt;
    n   = 0;
    cyc = 0;
    @(negedge clk);
    cmd_word  = vecs[2].word;
    cmd_read  = 1'b0;
    cmd_valid = 1'b1;
    while (n < 3 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) n++;
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_rsp_count", 128'(n), 128'(3));
    check("hold_accepts", 128'(acc_cnt - acc_base), 128'(3));
    check("hold_rsp_data0_kept", 128'(rsp_data0), 128'(32'hDEAD_BEEF));
    check("onehot_busy_insel_violations", 128'(viol), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
